// File: rtl/pipelined_alu.sv
// Fixed-latency pipelined ALU: result computed in stage 1, then delayed.
// Optional multiplier enabled by defining ALU_MUL_EN.
module pipelined_alu #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             valid
);

  typedef struct packed {
    logic             c;
    logic [WIDTH-1:0] d;
  } stg_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_NOT = 3'd6;

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_dif;
  stg_t           w_res;
`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] w_prod;
`endif

  stg_t r_stg [LATENCY];
  logic r_vld [LATENCY];

  assign w_sum = {1'b0, left} + {1'b0, right};
  // borrow appears as the top bit of the widened difference
  assign w_dif = {1'b0, left} - {1'b0, right};
`ifdef ALU_MUL_EN
  assign w_prod = {{WIDTH{1'b0}}, left}
                * {{WIDTH{1'b0}}, right};
`endif

  always_comb begin
    w_res = '0;
    case (op)
      OP_ADD: w_res = {w_sum[WIDTH], w_sum[WIDTH-1:0]};
      OP_SUB: w_res = {w_dif[WIDTH], w_dif[WIDTH-1:0]};
`ifdef ALU_MUL_EN
      OP_MUL: w_res = {|w_prod[2*WIDTH-1:WIDTH],
                       w_prod[WIDTH-1:0]};
`endif
      OP_AND: w_res = {1'b0, left & right};
      OP_OR:  w_res = {1'b0, left | right};
      OP_XOR: w_res = {1'b0, left ^ right};
      OP_NOT: w_res = {1'b0, ~left};
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < LATENCY; k++) begin
        r_stg[k] <= '0;
        r_vld[k] <= 1'b0;
      end
    end else begin
      r_vld[0] <= go;
      if (go) r_stg[0] <= w_res;
      for (int k = 1; k < LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) r_stg[k] <= r_stg[k-1];
      end
    end
  end

  assign out   = r_stg[LATENCY-1].d;
  assign carry = r_stg[LATENCY-1].c;
  assign valid = r_vld[LATENCY-1];

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed bench for pipelined_alu: table of single ops plus
// back-to-back, gap, reset and latency-variant sequences.
module tb_pipelined_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [2:0]  op;
  logic [31:0] left, right;

  logic [31:0] o2, o1, o4;
  logic        c2, c1, c4;
  logic        v2, v1, v4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipelined_alu #(.WIDTH(32), .LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .go(go), .op(op),
    .left(left), .right(right),
    .out(o2), .carry(c2), .valid(v2));

  pipelined_alu #(.WIDTH(32), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .go(go), .op(op),
    .left(left), .right(right),
    .out(o1), .carry(c1), .valid(v1));

  pipelined_alu #(.WIDTH(32), .LATENCY(4)) u4 (
    .clk(clk), .reset(reset), .go(go), .op(op),
    .left(left), .right(right),
    .out(o4), .carry(c4), .valid(v4));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] o;
    logic        c;
  } vec_t;

  vec_t tv [15];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [31:0] l,
                       input logic [31:0] r);
    go = 1'b1; op = o; left = l; right = r;
  endtask

  task automatic idle();
    go = 1'b0; op = 'x; left = 'x; right = 'x;
  endtask

  task automatic chk2(input string nm, input logic v,
                      input logic [31:0] o, input logic c);
    chk({nm, ".valid"}, {63'd0, v2}, {63'd0, v});
    chk({nm, ".out"}, {32'd0, o2}, {32'd0, o});
    chk({nm, ".carry"}, {63'd0, c2}, {63'd0, c});
  endtask

  initial begin
    tv[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1};
    tv[1]  = '{3'd0, 32'h2, 32'h3, 32'h5, 1'b0};
    tv[2]  = '{3'd1, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b1};
    tv[3]  = '{3'd1, 32'h7, 32'h5, 32'h2, 1'b0};
    tv[4]  = '{3'd1, 32'h5, 32'h5, 32'h0, 1'b0};
`ifdef ALU_MUL_EN
    tv[5]  = '{3'd2, 32'h1_0000, 32'h1_0000, 32'h0, 1'b1};
    tv[6]  = '{3'd2, 32'h3, 32'h5, 32'hF, 1'b0};
    tv[7]  = '{3'd2, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 1'b1};
`else
    tv[5]  = '{3'd2, 32'h1_0000, 32'h1_0000, 32'h0, 1'b0};
    tv[6]  = '{3'd2, 32'h3, 32'h5, 32'h0, 1'b0};
    tv[7]  = '{3'd2, 32'hFFFF_FFFF, 32'h2, 32'h0, 1'b0};
`endif
    tv[8]  = '{3'd3, 32'hF0, 32'h3C, 32'h30, 1'b0};
    tv[9]  = '{3'd4, 32'hF0, 32'h0F, 32'hFF, 1'b0};
    tv[10] = '{3'd5, 32'hA, 32'h5, 32'hF, 1'b0};
    tv[11] = '{3'd5, 32'hFFFF_0000, 32'hFF00_FF00,
               32'h00FF_FF00, 1'b0};
    tv[12] = '{3'd6, 32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0};
    tv[13] = '{3'd6, 32'h1234_5678, 32'h0, 32'hEDCB_A987, 1'b0};
    tv[14] = '{3'd7, 32'h1, 32'h1, 32'h0, 1'b0};

    // reset held with random traffic
    reset = 1'b0;
    idle();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk2("rst_hold", 1'b0, 32'h0, 1'b0);
      go = 1'(i % 2 == 0);
      op = 3'($urandom_range(0, 7));
      left = $urandom;
      right = $urandom;
    end
    @(negedge clk);
    reset = 1'b1;
    idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk2("rst_post", 1'b0, 32'h0, 1'b0);
    end

    // table of isolated ops, with hold check after each
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tv[i].op, tv[i].l, tv[i].r);
      @(negedge clk);
      idle();
      chk("tbl.v_early", {63'd0, v2}, 64'd0);
      @(negedge clk);
      chk2($sformatf("tbl%0d", i), 1'b1, tv[i].o, tv[i].c);
      @(negedge clk);
      chk2($sformatf("tbl%0d_hold", i), 1'b0, tv[i].o, tv[i].c);
    end

    // back-to-back
    @(negedge clk); drive(3'd1, 32'h5, 32'h7);
    @(negedge clk); drive(3'd3, 32'hF0, 32'h3C);
    chk("b2b.v0", {63'd0, v2}, 64'd0);
    @(negedge clk);
    chk2("b2b_sub", 1'b1, 32'hFFFF_FFFE, 1'b1);
    drive(3'd6, 32'h0, 32'h0);
    @(negedge clk);
    chk2("b2b_and", 1'b1, 32'h30, 1'b0);
    idle();
    @(negedge clk);
    chk2("b2b_not", 1'b1, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    chk2("b2b_hold", 1'b0, 32'hFFFF_FFFF, 1'b0);

    // gap of one cycle between two ops
    @(negedge clk); drive(3'd5, 32'hA, 32'h5);
    @(negedge clk); idle();
    chk("gap.v0", {63'd0, v2}, 64'd0);
    @(negedge clk);
    chk2("gap_a", 1'b1, 32'hF, 1'b0);
    drive(3'd0, 32'h1, 32'h1);
    @(negedge clk); idle();
    chk2("gap_mid", 1'b0, 32'hF, 1'b0);
    @(negedge clk);
    chk2("gap_b", 1'b1, 32'h2, 1'b0);
    @(negedge clk);
    chk2("gap_end", 1'b0, 32'h2, 1'b0);

    // reset pulse while an op is in flight
    @(negedge clk); drive(3'd0, 32'h2, 32'h3);
    @(negedge clk); idle(); reset = 1'b0;
    @(negedge clk);
    chk2("mid_rst", 1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk2("mid_rst_after", 1'b0, 32'h0, 1'b0);
    end

    // go coincident with reset is dropped
    @(negedge clk); drive(3'd0, 32'h2, 32'h3); reset = 1'b0;
    @(negedge clk); idle(); reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk2("go_in_rst", 1'b0, 32'h0, 1'b0);
      chk("go_in_rst.v1", {63'd0, v1}, 64'd0);
      chk("go_in_rst.v4", {63'd0, v4}, 64'd0);
    end

    // latency variants: valid exactly 1, 2, 4 cycles later
    @(negedge clk); drive(3'd5, 32'hA, 32'h5);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      idle();
      chk($sformatf("lat1.v@%0d", k), {63'd0, v1},
          {63'd0, 1'(k == 1)});
      chk($sformatf("lat2.v@%0d", k), {63'd0, v2},
          {63'd0, 1'(k == 2)});
      chk($sformatf("lat4.v@%0d", k), {63'd0, v4},
          {63'd0, 1'(k == 4)});
      if (k == 1) chk("lat1.out", {32'd0, o1}, 64'hF);
      if (k == 4) chk("lat4.out", {32'd0, o4}, 64'hF);
    end
    chk("lat4.carry", {63'd0, c4}, 64'd0);
    chk("lat1.hold", {32'd0, o1}, 64'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
